// File: rtl/pla_affine_pkg.sv
// rtl/pla_affine_pkg.sv - shared state encoding and width helper for the affine sequencer
package pla_affine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Accumulator width: enough for k*a plus a carry from the addend.
    function automatic int aw_width(input int w, input int kw);
        return w + kw + 1;
    endfunction

endpackage

// File: rtl/pla_affine_seq.sv
// rtl/pla_affine_seq.sv - sequential shift-add evaluator of y = k*a + c with valid/ready handshakes
module pla_affine_seq
    import pla_affine_pkg::*;
#(
    parameter int W  = 7,
    parameter int KW = 3,
    parameter int CW = 1,
    parameter int OW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [KW-1:0] k,
    input  logic [CW-1:0] c,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] y,
    output logic          ovf
);

    localparam int AW   = aw_width(W, KW);
    localparam int CNTW = $clog2(KW) + 1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(KW - 1);

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [KW-1:0]   r_k;
    logic [AW-1:0]   r_acc;
    logic [CNTW-1:0] r_cnt;
    logic [OW-1:0]   r_y;
    logic            r_ovf;

    logic [AW-1:0]   w_a_ext;
    logic            w_kbit;
    logic [AW-1:0]   w_addend;
    logic [AW-1:0]   w_sum;
    logic [OW-1:0]   w_y_next;
    logic            w_ovf_next;

    // One partial product per CALC cycle through a single AW-wide adder.
    assign w_a_ext  = AW'(r_a);
    assign w_kbit   = |(r_k & (KW'(1) << r_cnt));
    assign w_addend = w_kbit ? (w_a_ext << r_cnt) : '0;
    assign w_sum    = r_acc + w_addend;

    generate
        if (OW < AW) begin : g_trunc
            assign w_y_next   = w_sum[OW-1:0];
            assign w_ovf_next = |w_sum[AW-1:OW];
        end else if (OW == AW) begin : g_exact
            assign w_y_next   = w_sum;
            assign w_ovf_next = 1'b0;
        end else begin : g_wide
            assign w_y_next   = {{(OW-AW){1'b0}}, w_sum};
            assign w_ovf_next = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_k     <= k;
                        r_acc   <= AW'(c);
                        r_cnt   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNTW'(1);
                    // Result registers load on the final step so y/ovf are valid with DONE.
                    if (r_cnt == LAST_CNT) begin
                        r_y     <= w_y_next;
                        r_ovf   <= w_ovf_next;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign y         = r_y;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pla_affine_seq.sv
// tb/tb_pla_affine_seq.sv - scoreboard bench for pla_affine_seq
module tb_pla_affine_seq;

    localparam int KW = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] a;
    logic [2:0] k;
    logic [0:0] c;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] y;
    logic       ovf;

    logic       in_valid8;
    logic       in_ready8;
    logic [6:0] a8;
    logic [2:0] k8;
    logic [0:0] c8;
    logic       out_valid8;
    logic       out_ready8;
    logic [7:0] y8;
    logic       ovf8;

    pla_affine_seq u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .k(k), .c(c), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf)
    );

    pla_affine_seq #(.W(7), .KW(3), .CW(1), .OW(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .k(k8), .c(c8), .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y;
        bit ovf;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_ov  = 1'b0;
    bit   rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, truncated to the output width.
    task automatic model(input int av, input int kv, input int cv, input int ow,
                         output int ey, output bit eovf);
        int v;
        v    = kv * av + cv;
        ey   = v % (1 << ow);
        eovf = (v >= (1 << ow));
    endtask

    task automatic send(input int av, input int kv, input int cv);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout in_ready=%0d required=1", in_ready);
            return;
        end
        a = 7'(av); k = 3'(kv); c = 1'(cv); in_valid = 1'b1;
        @(posedge clk);
        #1;
        model(av, kv, cv, 10, e.y, e.ovf);
        e.acc_cyc = cyc;
        sb.push_back(e);
        in_valid = 1'b0;
        a = 7'($urandom); k = 3'($urandom); c = 1'($urandom);
    endtask

    task automatic drain(input int limit);
        int t;
        t = 0;
        while (sb.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    check("latency", cyc - sb[0].acc_cyc, KW);
                end
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("y", y, e.y);
                check("ovf", ovf, e.ovf);
            end
            prev_ov <= out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic run8(input int av, input int kv, input int cv);
        int  ey;
        bit  eovf;
        bit  seen;
        seen = 1'b0;
        @(negedge clk);
        for (int t = 0; t < 20 && !in_ready8; t++) @(negedge clk);
        a8 = 7'(av); k8 = 3'(kv); c8 = 1'(cv); in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        model(av, kv, cv, 8, ey, eovf);
        for (int n = 1; n <= 10 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (out_valid8) begin
                seen = 1'b1;
                check("ow8_latency", n, KW);
                check("ow8_y", y8, ey);
                check("ow8_ovf", ovf8, eovf);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ow8_timeout out_valid=0 required=1");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int ey;
        bit eovf;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; k = '0; c = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; k8 = '0; c8 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_y", y, 0);
        check("reset_ovf", ovf, 0);

        send(127, 5, 1);
        send(99, 0, 1);
        send(127, 7, 1);
        drain(50);

        // Hold the result: outputs must stay put and input pulses must be ignored.
        out_ready = 1'b0;
        send(100, 6, 1);
        model(100, 6, 1, 10, ey, eovf);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i % 2 == 0);
            a = 7'($urandom); k = 3'($urandom); c = 1'($urandom);
            @(negedge clk);
            check("stall_y", y, ey);
            check("stall_ovf", ovf, eovf);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(20);

        // Abort an operation on its second CALC cycle.
        send(55, 7, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_y", y, 0);
        check("abort_ovf", ovf, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (KW + 3) @(negedge clk);
        send(13, 3, 0);
        drain(20);

        run8(127, 5, 1);
        run8(0, 0, 0);
        run8(63, 4, 1);
        run8(127, 7, 1);

        for (int av = 0; av < 128; av++)
            for (int kv = 0; kv < 8; kv++)
                for (int cv = 0; cv < 2; cv++)
                    send(av, kv, cv);
        drain(50);

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send($urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 1));
        end
        drain(200);
        rand_rdy = 1'b0;
        #2;
        out_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
